rv_mtimer: RTL

Memory-mapped RISC-V machine timer (mtime/mtimecmp) sitting directly downstream of the `riscVsim` co-simulation processor wrapper on its memory-mapped master bus. It decodes a 32-byte window, answers reads with one wait state, accepts byte-enabled writes with zero wait states, and drives the processor's `irq` input when the running 64-bit time reaches the compare value. It is the timer-interrupt source for co-simulated RISC-V programs.

---
 rtl/rv_mtimer_if.sv | 21 ++
 rtl/rv_mtimer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/rv_mtimer_if.sv
// Memory-mapped slave bus between the co-simulation processor wrapper and rv_mtimer.
// Reads are held until waitrequest drops; writes complete in a single cycle.
interface rv_mtimer_if;
    logic [31:0] address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, write, writedata, byteenable, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, writedata, byteenable, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/rv_mtimer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, 64-bit compare, level irq.
// Reads take one wait state; byte-enabled writes complete with zero wait states.
module rv_mtimer #(
    parameter logic [31:0] BASE_ADDR = 32'hAFFFFFC0
) (
    input  logic        clk,
    input  logic        reset,
    rv_mtimer_if.slave  bus,
    output logic        irq
);

    typedef enum logic {StIdle, StAck} state_e;

    state_e      state_q;
    logic [63:0] mtime_q;
    logic [63:0] cmp_q;
    logic        cnt_en_q;
    logic        irq_en_q;
    logic [15:0] prescale_q;
    logic [15:0] pcnt_q;
    logic [31:0] hi_shadow_q;
    logic [31:0] rdata_q;
    logic        irq_q;

    logic        hit;
    logic [2:0]  off;
    logic        wr_en;
    logic        rd_start;
    logic        tick;
    logic [63:0] mtime_inc;
    logic [31:0] rd_mux;
    logic [31:0] wr_old;
    logic [31:0] wr_word;
    logic        unused_addr;

    assign unused_addr = ^bus.address[1:0];

    always_comb begin
        hit       = (bus.address[31:5] == BASE_ADDR[31:5]);
        off       = bus.address[4:2];
        wr_en     = bus.write & hit;
        rd_start  = bus.read & hit & (state_q == StIdle);
        tick      = cnt_en_q & (pcnt_q == prescale_q);
        mtime_inc = mtime_q + 64'(tick);
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            3'd0:    rd_mux = mtime_q[31:0];
            3'd1:    rd_mux = hi_shadow_q;
            3'd2:    rd_mux = cmp_q[31:0];
            3'd3:    rd_mux = cmp_q[63:32];
            3'd4:    rd_mux = {30'd0, irq_en_q, cnt_en_q};
            3'd5:    rd_mux = {16'd0, prescale_q};
            default: rd_mux = '0;
        endcase
    end

    // Old value of the addressed word before any tick, so unwritten lanes keep pre-tick bytes.
    always_comb begin
        wr_old = '0;
        case (off)
            3'd0:    wr_old = mtime_q[31:0];
            3'd1:    wr_old = mtime_q[63:32];
            3'd2:    wr_old = cmp_q[31:0];
            3'd3:    wr_old = cmp_q[63:32];
            3'd4:    wr_old = {30'd0, irq_en_q, cnt_en_q};
            3'd5:    wr_old = {16'd0, prescale_q};
            default: wr_old = '0;
        endcase
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = bus.byteenable[i] ? bus.writedata[8*i +: 8] : wr_old[8*i +: 8];
        end
    end

    assign bus.waitrequest = rd_start;
    assign bus.readdata    = (state_q == StAck) ? rdata_q : 32'd0;
    assign irq             = irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mtime_q     <= '0;
            cmp_q       <= '1;
            cnt_en_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            prescale_q  <= '0;
            pcnt_q      <= '0;
            hi_shadow_q <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            irq_q <= irq_en_q & (mtime_q >= cmp_q);

            if (rd_start) begin
                rdata_q <= rd_mux;
                if (off == 3'd0) begin
                    hi_shadow_q <= mtime_q[63:32];
                end
                state_q <= StAck;
            end else begin
                state_q <= StIdle;
            end

            if (cnt_en_q) begin
                pcnt_q <= tick ? 16'd0 : pcnt_q + 16'd1;
            end
            mtime_q <= mtime_inc;

            if (wr_en) begin
                case (off)
                    3'd0: mtime_q <= {mtime_inc[63:32], wr_word};
                    3'd1: mtime_q <= {wr_word, mtime_inc[31:0]};
                    3'd2: cmp_q[31:0] <= wr_word;
                    3'd3: cmp_q[63:32] <= wr_word;
                    3'd4: begin
                        cnt_en_q <= wr_word[0];
                        irq_en_q <= wr_word[1];
                        pcnt_q   <= '0;
                    end
                    3'd5: begin
                        prescale_q <= wr_word[15:0];
                        pcnt_q     <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
